// File: rtl/image_audio_pkg.sv
// image_audio_pkg: state encoding and field widths shared by the serializer and the splitter.
package image_audio_pkg;
  typedef enum logic [1:0] {Idle, SendAddr, SendPixels, SendAudio} state_t;
  localparam int ADDR_W = 24;
  localparam int BYTE_W = 8;
  localparam int DIBIT_W = 2;
  localparam int ADDR_DIBITS = 12;
  localparam int BYTE_DIBITS = 4;
endpackage

// File: rtl/byte_dibit_shifter.sv
// byte_dibit_shifter: accepts COUNT bytes and emits each as four LSB-first dibits, prefetching on the last dibit.
module byte_dibit_shifter
  import image_audio_pkg::*;
#(
  parameter int COUNT = 320
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              ready,
  output logic              out_valid,
  output logic [1:0]        out_dibit,
  output logic              last
);
  localparam int CW = $clog2(COUNT + 1);
  logic [BYTE_W-1:0] hold;
  logic              full;
  logic [1:0]        dcnt;
  logic [CW-1:0]     acc;
  logic              draining;
  logic              take;
  // dcnt is the index of the dibit currently on the registered output
  assign draining  = full && dcnt != 2'(BYTE_DIBITS - 1);
  assign ready     = en && !draining && acc < CW'(COUNT);
  assign take      = ready && in_valid;
  assign out_valid = draining || take;
  assign out_dibit = draining ? hold[1:0] : take ? in_data[1:0] : 2'b00;
  assign last      = full && !draining && acc == CW'(COUNT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
      full <= 1'b0;
      dcnt <= '0;
      acc  <= '0;
    end else if (clr) begin
      full <= 1'b0;
      dcnt <= '0;
      acc  <= '0;
    end else if (draining) begin
      hold <= hold >> DIBIT_W;
      dcnt <= dcnt + 2'd1;
    end else if (take) begin
      hold <= in_data >> DIBIT_W;
      dcnt <= '0;
      full <= 1'b1;
      acc  <= acc + 1'b1;
    end else if (full) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/image_audio_serializer.sv
// image_audio_serializer: address + pixel + audio frame onto an LSB-first dibit stream.
// Audio section built only when IMAGE_AUDIO_SERIALIZER_AUDIO_EN is defined.
module image_audio_serializer
  import image_audio_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = 320,
  parameter int AUDIO_PER_FRAME  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic [ADDR_W-1:0] frame_addr,
  output logic              frame_ready,
  input  logic              pixel_valid,
  input  logic [BYTE_W-1:0] pixel,
  output logic              pixel_ready,
  input  logic              audio_valid,
  input  logic [BYTE_W-1:0] audio,
  output logic              audio_ready,
  output logic              axiov,
  output logic [1:0]        axiod,
  output logic              busy
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_sr;
  logic [3:0]        addr_cnt;
  logic              accept, addr_last, addr_run, clr;
  logic              pix_v, pix_last, aud_v;
  logic [1:0]        pix_d, aud_d;
  logic              axiov_n;
  logic [1:0]        axiod_n;
  assign frame_ready = state == Idle;
  assign accept      = frame_valid && frame_ready;
  assign clr         = state == Idle;
  assign addr_last   = state == SendAddr && addr_cnt == 4'(ADDR_DIBITS);
  assign addr_run    = state == SendAddr && !addr_last;
  byte_dibit_shifter #(.COUNT(PIXELS_PER_FRAME)) u_pixel (
    .clk(clk), .rst(rst), .clr(clr), .en(addr_last || state == SendPixels),
    .in_valid(pixel_valid), .in_data(pixel), .ready(pixel_ready),
    .out_valid(pix_v), .out_dibit(pix_d), .last(pix_last)
  );
`ifdef IMAGE_AUDIO_SERIALIZER_AUDIO_EN
  logic aud_last;
  byte_dibit_shifter #(.COUNT(AUDIO_PER_FRAME)) u_audio (
    .clk(clk), .rst(rst), .clr(clr), .en((state == SendPixels && pix_last) || state == SendAudio),
    .in_valid(audio_valid), .in_data(audio), .ready(audio_ready),
    .out_valid(aud_v), .out_dibit(aud_d), .last(aud_last)
  );
`else
  logic unused_audio;
  assign unused_audio = &{1'b0, audio_valid, audio};
  assign audio_ready  = 1'b0;
  assign aud_v        = 1'b0;
  assign aud_d        = 2'b00;
`endif
  always_comb begin
    state_n = state;
    case (state)
      Idle:       state_n = accept ? SendAddr : Idle;
      SendAddr:   state_n = addr_last ? SendPixels : SendAddr;
`ifdef IMAGE_AUDIO_SERIALIZER_AUDIO_EN
      SendPixels: state_n = pix_last ? SendAudio : SendPixels;
      default:    state_n = aud_last ? Idle : SendAudio;
`else
      SendPixels: state_n = pix_last ? Idle : SendPixels;
      default:    state_n = Idle;
`endif
    endcase
  end
  // the shifters drive zero when inactive, so their outputs simply OR together
  assign axiov_n = accept || addr_run || pix_v || aud_v;
  assign axiod_n = accept ? frame_addr[1:0] : addr_run ? addr_sr[1:0] : pix_d | aud_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= Idle;
      axiov    <= 1'b0;
      axiod    <= 2'b00;
      busy     <= 1'b0;
      addr_sr  <= '0;
      addr_cnt <= '0;
    end else begin
      state <= state_n;
      axiov <= axiov_n;
      axiod <= axiod_n;
      busy  <= state_n != Idle;
      if (accept) begin
        addr_sr  <= frame_addr >> DIBIT_W;
        addr_cnt <= 4'd1;
      end else if (addr_run) begin
        addr_sr  <= addr_sr >> DIBIT_W;
        addr_cnt <= addr_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_image_audio_serializer.sv
// tb_image_audio_serializer: randomized frames checked against a dibit-queue model of the frame format.
module tb_image_audio_serializer;
  localparam int NP = 4;
  localparam int NA = 2;
`ifdef IMAGE_AUDIO_SERIALIZER_AUDIO_EN
  localparam int TOTAL = 12 + 4 * NP + 4 * NA;
`else
  localparam int TOTAL = 12 + 4 * NP;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic [23:0] frame_addr = '0;
  logic        frame_ready;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel = '0;
  logic        pixel_ready;
  logic        audio_valid = 1'b0;
  logic [7:0]  audio = '0;
  logic        audio_ready;
  logic        axiov;
  logic [1:0]  axiod;
  logic        busy;
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  logic [7:0] pix_src[NP];
  logic [7:0] aud_src[NA];
  int gaps;
  int lat;
  int pcount;
  int acount;
  always #5 clk = ~clk;
  image_audio_serializer #(.PIXELS_PER_FRAME(NP), .AUDIO_PER_FRAME(NA)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_addr(frame_addr),
    .frame_ready(frame_ready), .pixel_valid(pixel_valid), .pixel(pixel),
    .pixel_ready(pixel_ready), .audio_valid(audio_valid), .audio(audio),
    .audio_ready(audio_ready), .axiov(axiov), .axiod(axiod), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic push_val(input logic [31:0] v, input int nd);
    for (int i = 0; i < nd; i++) exp_q.push_back(2'((v >> (2 * i)) & 32'd3));
  endtask
  task automatic randomize_src();
    for (int i = 0; i < NP; i++) pix_src[i] = 8'($urandom);
    for (int i = 0; i < NA; i++) aud_src[i] = 8'($urandom);
  endtask
  // mode 0: sources always valid, 1: random valid, 2: one 5-cycle pixel underrun
  task automatic run_frame(input logic [23:0] addr, input int mode);
    int pi = 0, ai = 0, ucnt = 0, cyc = 0, acc_cyc = 0;
    bit took = 0, started = 0, udone = 0, pv, av;
    exp_q.delete();
    obs_q.delete();
    gaps = 0;
    lat = -1;
    push_val(32'(addr), 12);
    for (int i = 0; i < NP; i++) push_val(32'(pix_src[i]), 4);
`ifdef IMAGE_AUDIO_SERIALIZER_AUDIO_EN
    for (int i = 0; i < NA; i++) push_val(32'(aud_src[i]), 4);
`endif
    while ((exp_q.size() > 0 || !took) && cyc < 2000) begin
      if (axiov) begin
        obs_q.push_back(axiod);
        if (!started) begin
          started = 1;
          lat = cyc - acc_cyc;
        end
        chk("dibit", 32'(axiod), 32'(exp_q.pop_front()));
      end else if (started) gaps++;
      chk("ready_excl", 32'(pixel_ready && audio_ready), 0);
`ifndef IMAGE_AUDIO_SERIALIZER_AUDIO_EN
      chk("audio_ready_tied", 32'(audio_ready), 0);
`endif
      frame_valid = 1'b1;
      frame_addr = took ? 24'($urandom) : addr;
      if (mode == 2 && pi == 2 && pixel_ready && ucnt == 0 && !udone) begin
        ucnt = 5;
        udone = 1;
      end
      pv = (pi < NP) && (mode != 1 || $urandom_range(0, 3) != 0) && ucnt == 0;
      if (ucnt > 0) ucnt--;
      av = (ai < NA) && (mode != 1 || $urandom_range(0, 3) != 0);
      pixel_valid = pv;
      pixel = pv ? pix_src[pi] : 8'($urandom);
      audio_valid = av;
      audio = av ? aud_src[ai] : 8'($urandom);
      #1;
      if (frame_valid && frame_ready && !took) begin
        took = 1;
        acc_cyc = cyc;
      end
      if (pixel_valid && pixel_ready) pi++;
      if (audio_valid && audio_ready) ai++;
      @(negedge clk);
      cyc++;
    end
    pcount = pi;
    acount = ai;
    frame_valid = 1'b0;
    pixel_valid = 1'b0;
    audio_valid = 1'b0;
    chk("frame_done", 32'(exp_q.size()), 0);
    chk("latency", 32'(lat), 1);
    chk("pix_count", 32'(pcount), NP);
`ifdef IMAGE_AUDIO_SERIALIZER_AUDIO_EN
    chk("aud_count", 32'(acount), NA);
`else
    chk("aud_count", 32'(acount), 0);
`endif
    chk("dibit_total", 32'(obs_q.size()), TOTAL);
    chk("end_axiov", 32'(axiov), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_frame_ready", 32'(frame_ready), 1);
  endtask
  initial begin
    logic [1:0] addr_tbl[12] = '{3, 3, 2, 3, 1, 3, 0, 3, 3, 2, 2, 2};
    logic [1:0] pix_tbl[4] = '{0, 1, 3, 2};
    logic [1:0] aud_tbl[8] = '{2, 3, 1, 0, 3, 3, 3, 3};
    repeat (3) @(negedge clk);
    chk("rst_axiov", 32'(axiov), 0);
    chk("rst_axiod", 32'(axiod), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pixel_ready", 32'(pixel_ready), 0);
    chk("rst_audio_ready", 32'(audio_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_frame_ready", 32'(frame_ready), 1);
    @(negedge clk);
    randomize_src();
    pix_src[0] = 8'hB4;
    aud_src[0] = 8'h1E;
    aud_src[1] = 8'hFF;
    run_frame(24'hABCDEF, 0);
    chk("continuous_gaps", 32'(gaps), 0);
    for (int i = 0; i < 12; i++) chk("addr_tbl", 32'(obs_q[i]), 32'(addr_tbl[i]));
    for (int i = 0; i < 4; i++) chk("pix_tbl", 32'(obs_q[12 + i]), 32'(pix_tbl[i]));
`ifdef IMAGE_AUDIO_SERIALIZER_AUDIO_EN
    for (int i = 0; i < 8; i++) chk("aud_tbl", 32'(obs_q[12 + 4 * NP + i]), 32'(aud_tbl[i]));
`endif
    randomize_src();
    run_frame(24'($urandom), 2);
    chk("underrun_gaps", 32'(gaps), 5);
    for (int f = 0; f < 3; f++) begin
      randomize_src();
      run_frame(24'($urandom), 1);
    end
    repeat (3) @(negedge clk);
    frame_valid = 1'b1;
    frame_addr = 24'h123456;
    pixel_valid = 1'b1;
    pixel = 8'h5A;
    audio_valid = 1'b1;
    audio = 8'hC3;
    repeat (16) @(negedge clk);
    frame_valid = 1'b0;
    chk("pre_reset_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_axiov", 32'(axiov), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_pixel_ready", 32'(pixel_ready), 0);
    pixel_valid = 1'b0;
    audio_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    randomize_src();
    run_frame(24'($urandom), 1);
    randomize_src();
    run_frame(24'($urandom), 0);
    chk("post_reset_gaps", 32'(gaps), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/image_audio_serializer.md
Name: image_audio_serializer

Overview:
- Transmit-side counterpart of the FPGA1 image/audio splitter.
- Takes one 24-bit address, then a fixed-length burst of pixel bytes, then a fixed-length burst of audio bytes.
- Serialises the frame onto a 2-bit dibit stream (axiov/axiod) that the splitter consumes directly.
- Sits between the frame-buffer/audio sources and the Ethernet TX path.

Parameters:
- PIXELS_PER_FRAME, 320, pixel bytes sent after each address (must be >= 1).
- AUDIO_PER_FRAME, 16, audio bytes sent after the pixel section (must be >= 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- frame_valid  input  1  frame_addr is valid; request to start a frame.
- frame_addr  input  24  address word for the frame.
- frame_ready  output  1  high only in Idle; frame accepted when frame_valid && frame_ready.
- pixel_valid  input  1  pixel byte available.
- pixel  input  8  pixel byte.
- pixel_ready  output  1  pixel byte accepted when pixel_valid && pixel_ready.
- audio_valid  input  1  audio byte available.
- audio  input  8  audio byte.
- audio_ready  output  1  audio byte accepted when audio_valid && audio_ready.
- axiov  output  1  axiod carries a valid dibit this cycle.
- axiod  output  2  serial dibit.
- busy  output  1  high in every state except Idle.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: state=Idle, axiov=0, axiod=2'b00, busy=0, pixel_ready=0, audio_ready=0. frame_ready is combinational and equals 1 once rst deasserts.
- Reset mid-frame aborts immediately. The partial frame is dropped; there is no resume.
- Bit order: LSB dibit first for every field. Byte b is sent as b[1:0], b[3:2], b[5:4], b[7:6]. Address is sent as addr[1:0] … addr[23:22] (12 dibits). This matches the receiver's {axiod, reg[N-1:2]} shift-in.
- All of axiov, axiod and busy are registered.
- States:
  - Idle: frame_ready=1. On accept, latch frame_addr into a 24-bit shift register; next state SendAddr. Latency: the accept cycle is N; the first address dibit appears with axiov=1 at N+1.
  - SendAddr: 12 consecutive cycles with axiov=1, shift right by 2 each cycle. After the 12th dibit, go to SendPixels.
  - SendPixels: 8-bit holding shift register, dibit counter 0..3, byte counter 0..PIXELS_PER_FRAME-1.
    - pixel_ready = (holding empty || dibit_cnt==3) && bytes_accepted < PIXELS_PER_FRAME.
    - pixel_ready may assert during the last address dibit, so the first pixel dibit immediately follows the address.
    - A byte accepted in cycle N emits dibits at N+1..N+4. With pixel_valid held high, axiov stays continuous.
    - Underrun (holding empty, pixel_valid=0): axiov=0 and axiod holds 2'b00 until data arrives. There is no timeout.
    - After the last dibit of byte PIXELS_PER_FRAME-1, go to SendAudio.
  - SendAudio: identical mechanics on the audio ports with AUDIO_PER_FRAME. audio_ready may prefetch on the last pixel dibit. After the last audio dibit, go to Idle; axiov=0 the following cycle.
- frame_valid is ignored while busy=1. A new frame may be accepted in the first Idle cycle.
- Counter widths: $clog2(param+1). No wrap is allowed within a frame.
- Data stability: input data is sampled only on the handshake cycle. Changes while ready=0 are ignored.
- pixel_ready and audio_ready are never high in the same cycle.

Optional Feature:
- Macro: IMAGE_AUDIO_SERIALIZER_AUDIO_EN.
- Defined: frame = address, pixels, audio, as above.
- Undefined:
  - SendAudio is not built; after the last pixel dibit the block returns to Idle.
  - audio_ready is tied 0; audio_valid and audio are ignored.
  - AUDIO_PER_FRAME is unused.

Decomposition:
- Shared package image_audio_pkg:
  - state enum {Idle, SendAddr, SendPixels, SendAudio}, shared with the splitter;
  - ADDR_W=24, BYTE_W=8, DIBIT_W=2;
  - ADDR_DIBITS=12, BYTE_DIBITS=4.
- One natural sub-module, byte_dibit_shifter: holding register, dibit counter, prefetch ready and valid output. Instantiated twice (pixel, audio). The address path is handled inline.

Test Plan:
- Address: frame_addr=24'hABCDEF, sources always valid → from N+1, axiod = 3,3,2,3,1,3,0,3,3,2,2,2 with axiov=1 for 12 cycles.
- Pixel order and continuity: first pixel=8'hB4 → next four dibits 0,1,3,2. With PIXELS_PER_FRAME=4 and valid held high, axiov stays continuous for 12+16 cycles.
- Underrun: pixel_valid=0 for 5 cycles mid-section → axiov=0 for exactly 5 cycles, no dibit lost or duplicated, byte count still 4.
- End of frame: AUDIO_PER_FRAME=2, audio bytes 8'h1E, 8'hFF → dibits 2,3,1,0,3,3,3,3. The next cycle has axiov=0, busy=0, frame_ready=1.
- Reset: assert rst during SendPixels → axiov=0, busy=0 and pixel_ready=0 asynchronously. After release, a new frame starts cleanly with its address first.
- Loopback and macro: feed the output into the splitter and compare addr/pixel/audio against sources across 3 back-to-back frames. Repeat with IMAGE_AUDIO_SERIALIZER_AUDIO_EN undefined → no audio dibits and audio_ready never 1.
